// File: rtl/seg_scan_bcd.sv
// Time-multiplexed seven-segment driver for packed BCD digits.
// Digits are snapshotted once per frame, with leading-zero blanking and anti-ghosting blank time.
module seg_scan_bcd #(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     P_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0]     P_BLANK  = PW'(BLANK_CYC);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // XOR-ing an active-high value with these "off" patterns applies the output polarity.
  localparam logic [6:0]        SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{AN_ACTIVE_LOW}};

  logic [PW-1:0]       p;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] snap_bcd;
  logic [DIGITS-1:0]   snap_dp;
  logic                snap_lz;

  logic [DIGITS-1:0]   lz_blank;
  logic                zero_run;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                cur_blank;
  logic [DIGITS-1:0]   cur_onehot;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Walk from the most significant digit down; the run of blankable zeros ends at the first non-zero or dp.
  always_comb begin
    zero_run = snap_lz;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (snap_bcd[4*i +: 4] == 4'd0) && !snap_dp[i];
      lz_blank[i] = zero_run && (i != 0);
    end
  end

  always_comb begin
    cur_code   = 4'd0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_code      = snap_bcd[4*i +: 4];
        cur_dp        = snap_dp[i];
        cur_blank     = lz_blank[i];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      p          <= '0;
      idx        <= '0;
      snap_bcd   <= '0;
      snap_dp    <= '0;
      snap_lz    <= 1'b0;
      frame_done <= 1'b0;
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      an         <= AN_OFF;
    end else begin
      frame_done <= 1'b0;
      if (p == P_LAST) begin
        p <= '0;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          snap_bcd   <= bcd_in;
          snap_dp    <= dp_in;
          snap_lz    <= blank_lz;
          frame_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        p <= p + 1'b1;
      end

      if ((p < P_BLANK) || cur_blank) begin
        seg <= SEG_OFF;
        dp  <= DP_OFF;
        an  <= AN_OFF;
      end else begin
        seg <= decode(cur_code) ^ SEG_OFF;
        dp  <= cur_dp ^ DP_OFF;
        an  <= cur_onehot ^ AN_OFF;
      end
    end
  end

endmodule

// File: doc/seg_scan_bcd.md
Name: seg_scan_bcd

Overview:
Time-multiplexed seven-segment display driver that sits directly downstream of the BCD counter chain. It takes DIGITS packed BCD digits and scans them onto a common-anode/cathode display one digit at a time. Digits are captured once per frame so the display never tears. It also provides leading-zero blanking, per-digit decimal points, anti-ghosting blank time and a frame-done pulse.

Parameters:
DIGITS, 4, number of digits scanned (legal 1..8)
SCAN_DIV, 50000, sys_clk cycles per digit slot (legal >= 2)
BLANK_CYC, 500, cycles at start of each slot with all anodes off (legal 0..SCAN_DIV-1)
SEG_ACTIVE_LOW, 1, 1 = seg/dp outputs active-low
AN_ACTIVE_LOW, 1, 1 = an outputs active-low

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  synchronous reset, active-low
bcd_in  input  4*DIGITS  packed digits, digit 0 (rightmost) in bits [3:0]
dp_in  input  DIGITS  decimal point request per digit, bit i = digit i
blank_lz  input  1  1 = blank leading zeros
seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a
dp  output  1  decimal point of the currently driven digit
an  output  DIGITS  digit enables, bit i = digit i
frame_done  output  1  one-cycle pulse at the start of each frame

Behaviour:
- One clock (sys_clk). Reset is synchronous and active-low (sys_rst_n); it is sampled only on the rising edge.
- Reset state:
  - prescaler p=0, slot index idx=0.
  - snapshot registers (snap_bcd, snap_dp, snap_lz) = 0.
  - an, seg and dp all inactive (polarity per parameters).
  - frame_done=0.
- Prescaler:
  - Each cycle, if p==SCAN_DIV-1 then p<=0 and idx advances (DIGITS-1 wraps to 0); otherwise p<=p+1.
- Frame capture:
  - When p==SCAN_DIV-1 and idx==DIGITS-1, load snap_bcd<=bcd_in, snap_dp<=dp_in, snap_lz<=blank_lz.
  - In that same cycle, set frame_done<=1 for exactly one cycle. It is therefore high in the cycle where p==0 and idx==0.
  - Input changes at any other time have no visible effect until the next capture.
- Output registers, computed from the current p, idx and snapshot; visible outputs lag by 1 cycle:
  - If p<BLANK_CYC, or digit idx is lz-blanked: an, seg and dp all inactive.
  - Otherwise: an = one-hot(idx), seg = decode(snap_bcd[idx]), dp = snap_dp[idx].
  - Apply active-low inversion last.
- Decode (active-high form):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 = 40 (dash, segment g only).
- Leading-zero blanking (only when snap_lz=1):
  - Digit i is blanked iff it and every higher digit have code 0 and dp bit 0.
  - Digit 0 is never blanked.
  - A non-zero digit or a set dp stops blanking for itself and all lower digits.
- Reset mid-operation: outputs go inactive on the next edge, and scanning restarts from idx=0, p=0 with a zero snapshot.
- The first frame after reset displays the zero snapshot. With snap_lz=0 this shows all digits as "0".

Test Plan:
- Reset behaviour (DIGITS=4, SCAN_DIV=4, BLANK_CYC=1, active-low):
  - Hold sys_rst_n=0 for 3 cycles, then release.
  - Required: an=4'hF, seg=7'h7F, dp=1 throughout reset and in the first cycle after release.
  - Then an=4'hE and seg=7'h40 ("0") from cycle 2 to 4 after release.
  - First frame_done 16 cycles after release.
- Frame capture and scan order:
  - Apply bcd_in=16'h1234 before the first frame_done.
  - Required in the next frame: an=E/seg=19 ("4"), an=D/seg=30 ("3"), an=B/seg=24 ("2"), an=7/seg=79 ("1").
  - Each digit is active for 3 cycles, preceded by 1 all-off cycle.
- Leading-zero blanking:
  - blank_lz=1, bcd_in=16'h0070 -> digits 3 and 2 fully off, digit 1 shows "7" (seg=78), digit 0 shows "0".
  - bcd_in=16'h0000 -> only digit 0 lit with "0".
  - dp_in=4'b0100 with 16'h0000 -> digits 2, 1 and 0 lit, and dp=0 (active-low on) during digit 2.
- Tear-free update:
  - Change bcd_in from 16'h1111 to 16'h9999 midway through slot 1.
  - Required: the remainder of that frame still shows "1" (seg=79); "9" (seg=10) appears only after the next frame_done.
- Invalid codes: bcd_in=16'hABCF -> every digit shows dash (seg=3F in active-low).
- Reset mid-frame:
  - Assert sys_rst_n=0 for 1 cycle while idx=2.
  - Required: all outputs inactive on the next edge, snapshot cleared, scan restarts at digit 0, frame_done 16 cycles after release.
